// File: rtl/reg_writeback_unit_pkg.sv
// Shared widths and the writeback entry payload for the register-file write front end.
package reg_writeback_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Result channels, register-file write port and scoreboard query bundle.
interface reg_writeback_unit_if import reg_writeback_unit_pkg::*; ();

  logic              ld_valid;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              ld_ready;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;

  logic              WE3;
  logic [REG_AW-1:0] A3;
  logic [XLEN-1:0]   WD3;

  logic [REG_AW-1:0] q_a1;
  logic [REG_AW-1:0] q_a2;
  logic              busy1;
  logic              busy2;

  // Producers, decode and the register file
  modport master (
    output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, q_a1, q_a2,
    input  ld_ready, alu_ready, WE3, A3, WD3, busy1, busy2
  );

  // The writeback unit
  modport slave (
    input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, q_a1, q_a2,
    output ld_ready, alu_ready, WE3, A3, WD3, busy1, busy2
  );

endinterface

// File: rtl/reg_writeback_unit_wb_fifo.sv
// In-order writeback FIFO: up to two compacted writes and one read per cycle.
module reg_writeback_unit_wb_fifo import reg_writeback_unit_pkg::*; #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr0_en_i,
  input  wb_entry_t                     wr0_entry_i,
  input  logic                          wr1_en_i,
  input  wb_entry_t                     wr1_entry_i,
  input  logic                          pop_i,
  output wb_entry_t                     head_o,
  output logic [CW-1:0]                 count_o,
  output logic [DEPTH-1:0]              entry_valid_o,
  output logic [DEPTH-1:0][REG_AW-1:0]  entry_rd_o
);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, wr_ptr_p1;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   offs;

  // Pointer and occupancy next state; wr1 is only ever used together with wr0
  always_comb begin
    wr_ptr_p1 = wr_ptr_q + PW'(1);
    wr_ptr_d  = wr_ptr_q + PW'(wr0_en_i) + PW'(wr1_en_i);
    rd_ptr_d  = rd_ptr_q + PW'(pop_i);
    count_d   = count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(pop_i);
  end

  // Entry storage, left unreset since occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (wr0_en_i) mem_q[wr_ptr_q]  <= wr0_entry_i;
    if (wr1_en_i) mem_q[wr_ptr_p1] <= wr1_entry_i;
  end

  // Pointers and count, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Per-slot occupancy: a slot is live if it lies within count entries of the head
  always_comb begin
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs             = PW'(i) - rd_ptr_q;
      entry_rd_o[i]    = mem_q[i].rd;
      entry_valid_o[i] = (CW'(offs) < count_q);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback front end: arbitrates load/ALU results into a FIFO, drains one per
// cycle onto the register-file write port and reports pending writes to decode.
module reg_writeback_unit import reg_writeback_unit_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_writeback_unit_if.slave  wb
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]                count;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
  wb_entry_t                    head;

  logic      ld_ready, alu_ready;
  logic      enq_ld, enq_alu;
  logic      wr0_en, wr1_en, pop;
  wb_entry_t ld_entry, alu_entry, wr0_entry;

  logic              we3_q, we3_d;
  logic [REG_AW-1:0] a3_q, a3_d;
  logic [XLEN-1:0]   wd3_q, wd3_d;
  logic              busy1, busy2;

  // Readies from registered occupancy; load wins the last free slot
  always_comb begin
    ld_ready  = 1'b0;
    alu_ready = 1'b0;
    if (rst) begin
      ld_ready  = (count < CW'(DEPTH));
      alu_ready = (count <= CW'(DEPTH - 2)) ||
                  ((count == CW'(DEPTH - 1)) && !wb.ld_valid);
    end
  end

  // Enqueue compaction: load first, ALU second; rd 0 is accepted but dropped
  always_comb begin
    enq_ld    = wb.ld_valid  && ld_ready  && (wb.ld_rd  != '0);
    enq_alu   = wb.alu_valid && alu_ready && (wb.alu_rd != '0);
    ld_entry  = '{rd: wb.ld_rd,  data: wb.ld_data};
    alu_entry = '{rd: wb.alu_rd, data: wb.alu_data};
    wr0_en    = enq_ld || enq_alu;
    wr0_entry = enq_ld ? ld_entry : alu_entry;
    wr1_en    = enq_ld && enq_alu;
    pop       = (count != '0);
  end

  reg_writeback_unit_wb_fifo #(.DEPTH(DEPTH)) u_wb_fifo (
    .clk           (clk),
    .rst           (rst),
    .wr0_en_i      (wr0_en),
    .wr0_entry_i   (wr0_entry),
    .wr1_en_i      (wr1_en),
    .wr1_entry_i   (alu_entry),
    .pop_i         (pop),
    .head_o        (head),
    .count_o       (count),
    .entry_valid_o (ent_valid),
    .entry_rd_o    (ent_rd)
  );

  // Write-port next state: load the head when non-empty, otherwise hold address/data
  always_comb begin
    we3_d = pop;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (pop) begin
      a3_d  = head.rd;
      wd3_d = head.data;
    end
  end

  // Registered register-file write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
    end
  end

  // Pending-write scoreboard over live FIFO slots plus the in-flight write port
  always_comb begin
    busy1 = we3_q && (a3_q == wb.q_a1);
    busy2 = we3_q && (a3_q == wb.q_a2);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == wb.q_a1)) busy1 = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == wb.q_a2)) busy2 = 1'b1;
    end
    if (wb.q_a1 == '0) busy1 = 1'b0;
    if (wb.q_a2 == '0) busy2 = 1'b0;
  end

  assign wb.ld_ready  = ld_ready;
  assign wb.alu_ready = alu_ready;
  assign wb.WE3       = we3_q;
  assign wb.A3        = a3_q;
  assign wb.WD3       = wd3_q;
  assign wb.busy1     = busy1;
  assign wb.busy2     = busy2;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit with a FIFO scoreboard of expected writes.
module tb_reg_writeback_unit;
  import reg_writeback_unit_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_writeback_unit_if wb_if ();

  reg_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb_if)
  );

  int checks = 0;
  int errors = 0;

  wb_entry_t   m_q[$];
  logic        e_we;
  logic [4:0]  e_a3;
  logic [31:0] e_wd;
  logic [31:0] rf [32];
  logic        lacc, aacc;
  logic [31:0] last_ld [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic mbusy(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    if (e_we && (e_a3 == q)) return 1'b1;
    foreach (m_q[i]) if (m_q[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive, check readies, model the edge, check the write port and busy
  task automatic step(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic [4:0] qa1, input logic [4:0] qa2);
    int fr;
    logic m_lr, m_ar;
    wb_entry_t e;
    wb_if.ld_valid  = lv;
    wb_if.ld_rd     = lrd;
    wb_if.ld_data   = ldat;
    wb_if.alu_valid = av;
    wb_if.alu_rd    = ard;
    wb_if.alu_data  = adat;
    wb_if.q_a1      = qa1;
    wb_if.q_a2      = qa2;
    fr   = int'(DEPTH) - m_q.size();
    m_lr = rst && (fr >= 1);
    m_ar = rst && ((fr >= 2) || ((fr == 1) && !lv));
    #1;
    chk("ld_ready", 32'(wb_if.ld_ready), 32'(m_lr));
    chk("alu_ready", 32'(wb_if.alu_ready), 32'(m_ar));
    lacc = lv && m_lr;
    aacc = av && m_ar;
    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      e_we = 1'b0;
      e_a3 = 5'd0;
      e_wd = 32'd0;
    end else begin
      if (m_q.size() > 0) begin
        e    = m_q.pop_front();
        e_we = 1'b1;
        e_a3 = e.rd;
        e_wd = e.data;
      end else begin
        e_we = 1'b0;
      end
      if (lacc && (lrd != 5'd0)) m_q.push_back('{rd: lrd, data: ldat});
      if (aacc && (ard != 5'd0)) m_q.push_back('{rd: ard, data: adat});
    end
    #1;
    chk("WE3", 32'(wb_if.WE3), 32'(e_we));
    chk("A3", 32'(wb_if.A3), 32'(e_a3));
    chk("WD3", wb_if.WD3, e_wd);
    chk("busy1", 32'(wb_if.busy1), 32'(mbusy(qa1)));
    chk("busy2", 32'(wb_if.busy2), 32'(mbusy(qa2)));
    if (wb_if.WE3 === 1'b1) rf[wb_if.A3] = wb_if.WD3;
  endtask

  task automatic idle(input logic [4:0] qa1, input logic [4:0] qa2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa1, qa2);
  endtask

  initial begin
    int ai;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    for (int i = 0; i < 4; i++) last_ld[i] = 32'd0;
    e_we = 1'b0;
    e_a3 = 5'd0;
    e_wd = 32'd0;

    // Reset
    rst = 1'b0;
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    chk("rst_we3", 32'(wb_if.WE3), 32'd0);
    rst = 1'b1;

    // Single load: write port shows it two edges after accept
    step(1'b1, 5'd5, 32'h20, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("t1_busy_after_accept", 32'(wb_if.busy1), 32'd1);
    chk("t1_we3_early", 32'(wb_if.WE3), 32'd0);
    idle(5'd5, 5'd0);
    chk("t1_we3", 32'(wb_if.WE3), 32'd1);
    chk("t1_a3", 32'(wb_if.A3), 32'd5);
    chk("t1_wd3", wb_if.WD3, 32'h20);
    idle(5'd5, 5'd0);
    chk("t1_busy_clear", 32'(wb_if.busy1), 32'd0);
    idle(5'd5, 5'd0);
    chk("t1_rf5", rf[5], 32'h20);

    // Simultaneous load and ALU into an empty FIFO
    step(1'b1, 5'd6, 32'hA0, 1'b1, 5'd7, 32'h11, 5'd6, 5'd7);
    idle(5'd6, 5'd7);
    chk("t2_first_rd", 32'(wb_if.A3), 32'd6);
    idle(5'd6, 5'd7);
    chk("t2_second_rd", 32'(wb_if.A3), 32'd7);
    idle(5'd6, 5'd7);
    chk("t2_rf6", rf[6], 32'hA0);
    chk("t2_rf7", rf[7], 32'h11);

    // Fill: loads every cycle for 8 cycles, ALU rd 1..8 advanced on accept
    ai = 0;
    for (int c = 0; c < 40 && ai < 8; c++) begin
      step(logic'(c < 8), 5'(16 + c % 4), 32'h100 + 32'(c),
           1'b1, 5'(ai + 1), 32'hA000 + 32'(ai), 5'(ai + 1), 5'(16 + c % 4));
      if ((c < 8) && lacc) last_ld[c % 4] = 32'h100 + 32'(c);
      if (aacc) ai++;
    end
    chk("t3_alu_all_accepted", 32'(ai), 32'd8);
    for (int i = 0; i < 6; i++) idle(5'd1, 5'd16);
    for (int k = 1; k <= 8; k++) chk("t3_rf_alu", rf[k], 32'hA000 + 32'(k - 1));
    for (int k = 0; k < 4; k++) chk("t3_rf_ld", rf[16 + k], last_ld[k]);

    // rd 0 transfer is accepted but never written
    step(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    chk("t4_no_we3", 32'(wb_if.WE3), 32'd0);
    idle(5'd0, 5'd0);
    chk("t4_rf0", rf[0], 32'd0);

    // WAW on rd 3: ALU 0x1 then load 0x2
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h1, 5'd3, 5'd0);
    step(1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    idle(5'd3, 5'd0);
    chk("t5_busy_held", 32'(wb_if.busy1), 32'd1);
    idle(5'd3, 5'd0);
    idle(5'd3, 5'd0);
    chk("t5_rf3", rf[3], 32'h2);

    // Reset with three entries buffered
    step(1'b1, 5'd10, 32'h55, 1'b1, 5'd11, 32'h66, 5'd12, 5'd13);
    step(1'b1, 5'd12, 32'h77, 1'b1, 5'd13, 32'h88, 5'd12, 5'd13);
    rst = 1'b0;
    step(1'b1, 5'd14, 32'hE4, 1'b1, 5'd15, 32'hF5, 5'd12, 5'd13);
    chk("t6_we3", 32'(wb_if.WE3), 32'd0);
    chk("t6_a3", 32'(wb_if.A3), 32'd0);
    chk("t6_wd3", wb_if.WD3, 32'd0);
    step(1'b1, 5'd14, 32'hE4, 1'b1, 5'd15, 32'hF5, 5'd11, 5'd14);
    rst = 1'b1;
    step(1'b1, 5'd20, 32'h99, 1'b0, 5'd0, 32'd0, 5'd20, 5'd12);
    idle(5'd20, 5'd12);
    idle(5'd20, 5'd12);
    idle(5'd20, 5'd12);
    chk("t6_rf20", rf[20], 32'h99);
    chk("t6_rf12", rf[12], 32'd0);
    chk("t6_rf14", rf[14], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
